// File: rtl/pilot_sync_fifo_if.sv
// Handshake/status bundle for pilot_sync_fifo.
// The master side drives requests and data in; the slave side (the FIFO)
// returns the head word, occupancy and status flags.
interface pilot_sync_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic [WIDTH-1:0] pop_data;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;
  logic             err_clr;

  // Producer/consumer side: issues push/pop/err_clr, observes status.
  modport master (
    output push,
    output push_data,
    output pop,
    output err_clr,
    input  pop_data,
    input  full,
    input  empty,
    input  almost_full,
    input  almost_empty,
    input  count,
    input  overflow,
    input  underflow
  );

  // FIFO side.
  modport slave (
    input  push,
    input  push_data,
    input  pop,
    input  err_clr,
    output pop_data,
    output full,
    output empty,
    output almost_full,
    output almost_empty,
    output count,
    output overflow,
    output underflow
  );

endinterface

// File: rtl/pilot_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Occupancy is kept in a registered counter; all level flags are decoded from
// it, so they follow an accepted operation by one cycle. Pointers carry an
// extra wrap bit above the index bits. Rejected operations never touch
// pointers, count or storage; they only set the sticky error flags.
module pilot_sync_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pilot_sync_fifo_if.slave     bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);
  localparam logic [PW-1:0] ONE_C   = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count_q;
  logic [PW-1:0] count_next;

  logic          full_s;
  logic          empty_s;
  logic          push_ok;
  logic          pop_ok;
  logic          overflow_q;
  logic          underflow_q;

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  // Level flags come straight from the registered occupancy.
  assign full_s  = (count_q == DEPTH_C);
  assign empty_s = (count_q == '0);

  // A push into a full FIFO still goes through when a pop frees the head slot
  // in the same cycle; a pop from an empty FIFO never does.
  assign push_ok = bus.push & (~full_s | bus.pop);
  assign pop_ok  = bus.pop & ~empty_s;

  // Next occupancy: +1 for a lone push, -1 for a lone pop, else unchanged.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    count_next = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_q + ONE_C;
      2'b01:   count_next = count_q - ONE_C;
      default: count_next = count_q;
    endcase
  end

  // Storage write on accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the data array deliberately has no reset; validity is tracked by
    // the pointers and count, and leaving it unreset lets it map to RAM.
    if (push_ok) begin
      mem[wr_idx] <= bus.push_data;
    end
  end

  // Write/read pointers advance on their accepted operation and wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ONE_C;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ONE_C;
      end
    end
  end

  // Registered occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_next;
    end
  end

  // Sticky error flags: set on a rejected operation, cleared by err_clr; a
  // new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.push && full_s && !bus.pop) begin
        overflow_q <= 1'b1;
      end else if (bus.err_clr) begin
        overflow_q <= 1'b0;
      end

      if (bus.pop && empty_s) begin
        underflow_q <= 1'b1;
      end else if (bus.err_clr) begin
        underflow_q <= 1'b0;
      end
    end
  end

  // Head word is presented combinationally and forced to zero when empty.
  assign bus.pop_data     = empty_s ? '0 : mem[rd_idx];
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
